// File: rtl/exe_pkg.sv
// exe_pkg: opcodes, status codes and controller states shared by the exe arbiter slice
package exe_pkg;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_CONV = 2'b11;
    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ILLEGAL = 2'b01,
        ST_NEGZERO = 2'b10,
        ST_RSVD    = 2'b11
    } status_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/exe_arbiter_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, pointer names the favoured requester on contention
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);
    logic ptr;
    // lone requester wins outright; on contention the pointer decides
    always_comb grant = {valid[1] & (~valid[0] | ptr), valid[0] & (~valid[1] | ~ptr)};
    // after an accept the other requester becomes favoured
    always_ff @(posedge clk)
        if (rst) ptr <= 1'b0;
        else if (accept) ptr <= grant[0];
endmodule

// File: rtl/exe_arbiter_ctrl.sv
// exe_arbiter_ctrl: shares one combinational exe unit between two requesters with round-robin issue
module exe_arbiter_ctrl
    import exe_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [n-1:0] i_req0_oper,
    input  logic [m-1:0] i_req0_argA,
    input  logic [m-1:0] i_req0_argB,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [n-1:0] i_req1_oper,
    input  logic [m-1:0] i_req1_argA,
    input  logic [m-1:0] i_req1_argB,
    output logic [n-1:0] o_exe_oper,
    output logic [m-1:0] o_exe_argA,
    output logic [m-1:0] o_exe_argB,
    input  logic [m-1:0] i_exe_result,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [m-1:0] o_rsp_result,
    output logic         o_rsp_id,
    output logic [1:0]   o_rsp_status
);
    state_t        state, state_d;
    status_t       st_q, st_d;
    logic [1:0]    grant;
    logic          accept, id_q;
    logic [n-1:0]  oper_q;
    logic [m-1:0]  a_q, b_q, res_q;

    rr_arb2 u_arb (
        .clk   (i_clk),
        .rst   (i_rsn),
        .valid ({i_req1_valid, i_req0_valid}),
        .accept(accept),
        .grant (grant)
    );

    assign o_req0_ready = ~i_rsn & (state == IDLE) & grant[0];
    assign o_req1_ready = ~i_rsn & (state == IDLE) & grant[1];
    assign accept       = o_req0_ready | o_req1_ready;
    assign o_exe_oper   = oper_q;
    assign o_exe_argA   = a_q;
    assign o_exe_argB   = b_q;
    assign o_rsp_valid  = state == RESP;
    assign o_rsp_result = res_q;
    assign o_rsp_id     = id_q;
    assign o_rsp_status = st_q;

    // classify the captured opcode/operands into a response status
    always_comb st_d = (oper_q == n'(OP_CMP)) ? ST_OK :
                       (oper_q != n'(OP_CONV)) ? ST_ILLEGAL :
                       (a_q == {1'b1, {(m-1){1'b0}}}) ? ST_NEGZERO : ST_OK;

    // state register
    always_ff @(posedge i_clk)
        if (i_rsn) state <= IDLE;
        else state <= state_d;

    // next state: accept -> one exec cycle -> hold response until taken
    always_comb begin
        state_d = state;
        if (state == IDLE && accept) state_d = EXEC;
        else if (state == EXEC) state_d = RESP;
        else if (state == RESP && i_rsp_ready) state_d = IDLE;
    end

    // operand capture on accept, result/status capture at the end of exec
    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            oper_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            res_q  <= '0;
            st_q   <= ST_OK;
        end else begin
            if (accept) begin
                oper_q <= grant[1] ? i_req1_oper : i_req0_oper;
                a_q    <= grant[1] ? i_req1_argA : i_req0_argA;
                b_q    <= grant[1] ? i_req1_argB : i_req0_argB;
                id_q   <= grant[1];
            end
            if (state == EXEC) begin
                res_q <= (st_d == ST_ILLEGAL) ? '0 : i_exe_result;
                st_q  <= st_d;
            end
        end
    end
endmodule

// File: tb/tb_exe_arbiter_ctrl.sv
// tb_exe_arbiter_ctrl: directed stimulus, cycle-level reference model and per-cycle output comparison
module tb_exe_arbiter_ctrl;
    logic       clk = 0, rst = 1;
    logic       v0 = 0, v1 = 0, r0, r1, rsp_ready = 1, rsp_valid, rsp_id;
    logic [1:0] op0 = 0, op1 = 0, exe_oper, rsp_st;
    logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, exe_a, exe_b, exe_res, rsp_res;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    exe_arbiter_ctrl dut (
        .i_clk(clk), .i_rsn(rst),
        .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_oper(op0), .i_req0_argA(a0), .i_req0_argB(b0),
        .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_oper(op1), .i_req1_argA(a1), .i_req1_argB(b1),
        .o_exe_oper(exe_oper), .o_exe_argA(exe_a), .o_exe_argB(exe_b), .i_exe_result(exe_res),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_res),
        .o_rsp_id(rsp_id), .o_rsp_status(rsp_st)
    );

    // stand-in exe unit; illegal opcodes yield garbage the controller must discard
    function automatic logic [3:0] exe_unit(logic [1:0] op, logic [3:0] a, logic [3:0] b);
        if (op == 2'b01) return (a < b) ? 4'b0111 : 4'b0000;
        if (op == 2'b11) return a[3] ? (~{1'b0, a[2:0]}) + 4'd1 : a;
        return 4'b1010;
    endfunction
    assign exe_res = exe_unit(exe_oper, exe_a, exe_b);

    // expected {status, result} from the operation rules, using integer arithmetic
    function automatic logic [5:0] spec_eval(logic [1:0] op, logic [3:0] a, logic [3:0] b);
        int av = a, bv = b;
        if (op == 2'b01) return {2'b00, (av < bv) ? 4'd7 : 4'd0};
        if (op == 2'b11) begin
            if (av == 8) return {2'b10, 4'd0};
            if (av > 8) return {2'b00, 4'(16 - (av - 8))};
            return {2'b00, a};
        end
        return {2'b01, 4'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: age 0 = free, 1 = executing, 2 = response pending
    bit         model_ok = 0;
    int         age = 0, ptr = 0;
    logic [1:0] m_oper = 0, m_st = 0;
    logic [3:0] m_a = 0, m_b = 0, m_res = 0;
    logic       m_id = 0;
    logic [5:0] pend = 0;
    logic       e_r0, e_r1;
    assign e_r0 = model_ok && !rst && age == 0 && v0 && (!v1 || ptr == 0);
    assign e_r1 = model_ok && !rst && age == 0 && v1 && (!v0 || ptr == 1);

    always @(posedge clk) begin
        if (rst) begin
            model_ok <= 1; age <= 0; ptr <= 0;
            m_oper <= 0; m_a <= 0; m_b <= 0; m_id <= 0; m_res <= 0; m_st <= 0;
        end else if (model_ok) begin
            if (age == 0 && (e_r0 || e_r1)) begin
                m_oper <= e_r1 ? op1 : op0;
                m_a    <= e_r1 ? a1 : a0;
                m_b    <= e_r1 ? b1 : b0;
                m_id   <= e_r1;
                ptr    <= e_r1 ? 0 : 1;
                pend   <= e_r1 ? spec_eval(op1, a1, b1) : spec_eval(op0, a0, b0);
                age    <= 1;
            end else if (age == 1) begin
                {m_st, m_res} <= pend;
                age <= 2;
            end else if (age == 2 && rsp_ready) age <= 0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("ready0", r0, e_r0);
            chk("ready1", r1, e_r1);
            chk("rsp_valid", rsp_valid, age == 2);
            chk("exe_oper", exe_oper, m_oper);
            chk("exe_argA", exe_a, m_a);
            chk("exe_argB", exe_b, m_b);
            chk("rsp_result", rsp_res, m_res);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_status", rsp_st, m_st);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic [1:0] es, input string nm);
        bit got = 0;
        if (r == 0) begin v0 = 1; op0 = op; a0 = a; b0 = b; end
        else begin v1 = 1; op1 = op; a1 = a; b1 = b; end
        #1;
        for (int i = 0; i < 6 && !got; i++) if ((r == 0) ? r0 : r1) got = 1; else tick;
        chk({nm, "_accept"}, got, 1);
        tick;
        v0 = 0; v1 = 0;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) if (rsp_valid) got = 1; else tick;
        chk({nm, "_rsp"}, got, 1);
        chk({nm, "_result"}, rsp_res, er);
        chk({nm, "_id"}, rsp_id, r);
        chk({nm, "_status"}, rsp_st, es);
        rsp_ready = 1;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v0 = 1;
        tick; tick;
        chk("reset_ready0", r0, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        v0 = 0;
        rst = 0;
        // single request
        v0 = 1; op0 = 2'b01; a0 = 4'b0010; b0 = 4'b0101;
        #1 chk("single_ready0", r0, 1);
        tick;
        v0 = 0;
        chk("single_ready_drop", r0, 0);
        chk("single_exe_oper", exe_oper, 2'b01);
        chk("single_exe_a", exe_a, 4'b0010);
        chk("single_exe_b", exe_b, 4'b0101);
        chk("single_no_rsp_yet", rsp_valid, 0);
        tick;
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_result", rsp_res, 4'b0111);
        chk("single_id", rsp_id, 0);
        chk("single_status", rsp_st, 2'b00);
        tick;
        // contention with pointer freshly reset
        rst = 1; tick; rst = 0;
        v0 = 1; op0 = 2'b01; a0 = 4'd5; b0 = 4'd2;
        v1 = 1; op1 = 2'b11; a1 = 4'b0101; b1 = 4'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", r0, k % 2 == 0);
            chk("rr_ready1", r1, k % 2 == 1);
            tick; tick;
            chk("rr_rsp_valid", rsp_valid, 1);
            chk("rr_rsp_id", rsp_id, k % 2);
            chk("rr_rsp_result", rsp_res, (k % 2 == 0) ? 4'b0000 : 4'b0101);
            tick;
        end
        // backpressure on a conversion from requester 1
        v0 = 0; op1 = 2'b11; a1 = 4'b1011; rsp_ready = 0;
        #1 chk("bp_ready1", r1, 1);
        tick;
        v0 = 1;
        #1 chk("bp_exec_no_ready", r0 | r1, 0);
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_result", rsp_res, 4'b1101);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_hold_status", rsp_st, 2'b00);
            chk("bp_no_ready", r0 | r1, 0);
            tick;
        end
        rsp_ready = 1;
        #1 chk("bp_release_no_ready", r0, 0);
        tick;
        chk("bp_ready_returns", r0, 1);
        v0 = 0; v1 = 0;
        #1;
        // opcode corner cases
        do_op(0, 2'b10, 4'd3, 4'd4, 4'b0000, 2'b01, "illegal");
        do_op(0, 2'b11, 4'b1000, 4'd0, 4'b0000, 2'b10, "negzero");
        do_op(1, 2'b11, 4'b0110, 4'd0, 4'b0110, 2'b00, "conv_pos");
        do_op(1, 2'b01, 4'd9, 4'd3, 4'b0000, 2'b00, "cmp_false");
        // reset while executing
        v0 = 1; op0 = 2'b01; a0 = 4'd1; b0 = 4'd9;
        #1 chk("mid_ready0", r0, 1);
        tick;
        v0 = 0;
        chk("mid_in_exec", exe_oper, 2'b01);
        rst = 1;
        tick;
        rst = 0;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_exe_oper", exe_oper, 0);
        chk("mid_exe_a", exe_a, 0);
        chk("mid_exe_b", exe_b, 0);
        chk("mid_result", rsp_res, 0);
        chk("mid_id", rsp_id, 0);
        chk("mid_status", rsp_st, 0);
        tick;
        chk("mid_no_rsp", rsp_valid, 0);
        v0 = 1; v1 = 1;
        #1 chk("mid_ptr_zero", r0, 1);
        v0 = 0;
        #1 chk("mid_req1_ready", r1, 1);
        do_op(1, 2'b01, 4'd3, 4'd9, 4'b0111, 2'b00, "after_reset");
        tick; tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/exe_arbiter_ctrl.md
Name: exe_arbiter_ctrl

Overview:
Sequencer and arbiter that shares one combinational execution unit (compare / sign-magnitude-to-U2 conversion) between two requesters.
- Accepts operations through valid/ready handshakes and chooses between requesters with round-robin priority.
- Registers the operands, drives the unit for one cycle and captures the result.
- Returns the result on a response channel with a requester ID and status.
- Sits between the instruction-issue logic and the exe unit instance.

Parameters:
m, 4, operand/result width in bits
n, 2, opcode width in bits

Ports:
i_clk  in  1  system clock, rising edge
i_rsn  in  1  reset, synchronous, active-high
i_req0_valid  in  1  requester 0 has an operation
o_req0_ready  out  1  requester 0 operation accepted this cycle
i_req0_oper  in  n  requester 0 opcode
i_req0_argA  in  m  requester 0 operand A
i_req0_argB  in  m  requester 0 operand B
i_req1_valid, o_req1_ready, i_req1_oper, i_req1_argA, i_req1_argB  same as requester 0, for requester 1
o_exe_oper  out  n  opcode to exe unit
o_exe_argA  out  m  operand A to exe unit
o_exe_argB  out  m  operand B to exe unit
i_exe_result  in  m  combinational result from exe unit
o_rsp_valid  out  1  response available
i_rsp_ready  in  1  consumer takes response
o_rsp_result  out  m  captured result
o_rsp_id  out  1  requester that issued the operation
o_rsp_status  out  2  status code, see below

Behaviour:
- Reset: when i_rsn=1 at a rising edge, the block returns to IDLE regardless of current state.
  - Round-robin pointer = 0.
  - All operand, opcode, result, ID and status registers cleared to 0.
  - o_rsp_valid = 0; o_reqX_ready = 0 during the reset cycle.
  - An in-flight operation is dropped and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valids and the pointer.
    - Only one valid: grant it.
    - Both valid: grant the pointer's requester.
  - o_reqX_ready = (state==IDLE) && valid && granted. At most one ready is high at a time.
  - On accept: capture oper/argA/argB/ID, set pointer to the other requester, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - o_exe_* are driven from the captured registers. They hold those values in every state and are never driven from the inputs directly.
  - At the end of the cycle, capture i_exe_result and compute status, then go to RESP.
- RESP:
  - o_rsp_valid=1; result, ID and status are held stable.
  - On i_rsp_valid&&i_rsp_ready, i.e. o_rsp_valid && i_rsp_ready: go to IDLE. The next accept can happen at the earliest one cycle later; there is no same-cycle bypass.
  - No ready-high requests accepted while in EXEC or RESP.
- Latency: accept at edge T means o_rsp_valid is high from T+2. Throughput is at most 1 operation per 3 cycles.
- Opcodes (package): OP_CMP=2'b01 (result all-ones-except-MSB if A<B, else 0), OP_CONV=2'b11 (sign-magnitude A to U2). 2'b00 and 2'b10 are illegal.
- Status:
  - 00 OK.
  - 01 illegal opcode: result forced to 0, the EXEC cycle still occurs, the operands are still sent to the unit.
  - 10 negative-zero input on OP_CONV (argA == MSB-only): result is the captured value (0).
  - 11 reserved, never produced.
- Requester inputs may change while not ready; only values present at the accept edge are used.
- A requester deasserting valid before it is granted is legal; no operation is recorded.

Decomposition:
- Package exe_pkg holds:
  - opcode constants OP_CMP and OP_CONV;
  - status enum ST_OK, ST_ILLEGAL, ST_NEGZERO, ST_RSVD (2-bit);
  - state enum {IDLE, EXEC, RESP}.
- One natural sub-module: rr_arb2, a 2-input round-robin arbiter (combinational grant plus pointer register updated on accept).
- The exe unit is instantiated outside this block, at the parent level.

Test Plan:
- Single request: reset, then req0 oper=01 A=4'b0010 B=4'b0101 valid. Expect ready0 high for 1 cycle, o_exe_* = 01/0010/0101 in EXEC, rsp_valid at T+2 with result=0111, id=0, status=00.
- Round-robin contention: req0 and req1 held valid continuously, rsp_ready=1. Expect grant order 0,1,0,1 and ready pulses every 3 cycles, with responses carrying alternating id.
- Backpressure: OP_CONV A=4'b1011 on req1, rsp_ready=0 for 5 cycles. Expect rsp_valid held with result=1101, id=1, status=00 stable; no readys during the stall. Ready returns one cycle after rsp_ready rises.
- Illegal opcode and negative zero:
  - oper=10 on req0 -> result=0000, status=01.
  - oper=11 A=4'b1000 -> result=0000, status=10.
- Reset mid-operation: assert i_rsn during EXEC. Expect no response, rsp_valid=0, all outputs 0 and pointer=0 on the next cycle. A following req1-only request is granted normally.
